// File: rtl/ddr_a2m_reqdisp.sv
// AXI2MBA request dispatcher: pops merged AW/AR requests and emits MBA commands,
// splitting INCR bursts at P_MAXBL and (with DDR_A2M_REQDISP_BNDSPLIT_EN) at 2^P_BNDRY bytes.
module ddr_a2m_reqdisp #(
  parameter int P_IW    = 8,
  parameter int P_AW    = 40,
  parameter int P_MAXBL = 16,
  parameter int P_BNDRY = 12
) (
  input  logic            CLK,
  input  logic            ZRESET,
  input  logic            EMPTY,
  output logic            RE,
  input  logic [P_IW-1:0] AXID,
  input  logic [P_AW-1:0] AXADDR,
  input  logic [7:0]      AXLEN,
  input  logic [2:0]      AXSIZE,
  input  logic [1:0]      AXBURST,
  input  logic            AXLOCK,
  input  logic            AXDIR,
  output logic            MCMDVALID,
  input  logic            MCMDREADY,
  output logic [P_IW-1:0] MCMDID,
  output logic [P_AW-1:0] MCMDADDR,
  output logic [7:0]      MCMDLEN,
  output logic [2:0]      MCMDSIZE,
  output logic            MCMDDIR,
  output logic            MCMDLOCK,
  output logic            MCMDWRAP,
  output logic            MCMDLAST,
  output logic [1:0]      DBGSTATE
);

  // Handshake: a command transfers on a rising CLK where MCMDVALID & MCMDREADY;
  // MCMDVALID never drops and MCMD* never change until that transfer happens.

  if (P_MAXBL < 1 || P_MAXBL > 256 || (P_MAXBL & (P_MAXBL - 1)) != 0) begin : g_bad_maxbl
    $error("P_MAXBL must be a power of two in 1..256");
  end
  if (P_BNDRY < 1 || P_BNDRY > P_AW) begin : g_bad_bndry
    $error("P_BNDRY must be in 1..P_AW");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_CMD  = 2'd2
  } state_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  state_t          state_q;
  logic [P_AW-1:0] addr_q;
  logic [8:0]      rem_q;
  logic [8:0]      n_q;
  logic [2:0]      size_q;
  logic [1:0]      burst_q;
  logic [P_IW-1:0] id_q;
  logic            dir_q;
  logic            lock_q;

  logic            mvalid_q;
  logic [P_IW-1:0] mid_q;
  logic [P_AW-1:0] maddr_q;
  logic [7:0]      mlen_q;
  logic [2:0]      msize_q;
  logic            mdir_q;
  logic            mlock_q;
  logic            mwrap_q;
  logic            mlast_q;

  logic [P_AW-1:0] aligned_d;
  logic [P_AW-1:0] addr_d;
  logic [8:0]      n_d;
  logic [8:0]      n_lim;
  logic [8:0]      rem_d;

`ifdef DDR_A2M_REQDISP_BNDSPLIT_EN
  localparam int CW = (P_BNDRY + 1 > 9) ? P_BNDRY + 1 : 9;
  logic [CW-1:0] bnd_room;
  logic [CW-1:0] bnd_beats;
`endif

  always_comb begin
    aligned_d = addr_q & ~((P_AW'(1) << size_q) - P_AW'(1));
    n_lim     = (rem_q < 9'(P_MAXBL)) ? rem_q : 9'(P_MAXBL);
`ifdef DDR_A2M_REQDISP_BNDSPLIT_EN
    // Beats left before the boundary; at least 1 since the address is size-aligned.
    bnd_room  = (CW'(1) << P_BNDRY) - CW'(aligned_d[P_BNDRY-1:0]);
    bnd_beats = bnd_room >> size_q;
    if (bnd_beats < CW'(n_lim)) begin
      n_lim = 9'(bnd_beats);
    end
`endif
    case (burst_q)
      BURST_FIXED: n_d = 9'd1;
      BURST_WRAP:  n_d = rem_q;
      default:     n_d = n_lim;
    endcase
    addr_d = aligned_d + (P_AW'(n_q) << size_q);
    rem_d  = rem_q - n_q;
  end

  always_ff @(posedge CLK or negedge ZRESET) begin
    if (!ZRESET) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      n_q      <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      id_q     <= '0;
      dir_q    <= 1'b0;
      lock_q   <= 1'b0;
      mvalid_q <= 1'b0;
      mid_q    <= '0;
      maddr_q  <= '0;
      mlen_q   <= '0;
      msize_q  <= '0;
      mdir_q   <= 1'b0;
      mlock_q  <= 1'b0;
      mwrap_q  <= 1'b0;
      mlast_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!EMPTY) begin
            addr_q  <= AXADDR;
            rem_q   <= 9'(AXLEN) + 9'd1;
            size_q  <= AXSIZE;
            burst_q <= AXBURST;
            id_q    <= AXID;
            dir_q   <= AXDIR;
            lock_q  <= AXLOCK;
            state_q <= S_CALC;
          end
        end
        S_CALC: begin
          n_q      <= n_d;
          mvalid_q <= 1'b1;
          mid_q    <= id_q;
          maddr_q  <= addr_q;
          mlen_q   <= 8'(n_d - 9'd1);
          msize_q  <= size_q;
          mdir_q   <= dir_q;
          mlock_q  <= lock_q;
          mwrap_q  <= (burst_q == BURST_WRAP);
          mlast_q  <= (n_d == rem_q);
          state_q  <= S_CMD;
        end
        S_CMD: begin
          if (MCMDREADY) begin
            mvalid_q <= 1'b0;
            rem_q    <= rem_d;
            // FIXED keeps its address; WRAP always finishes here, so only INCR matters.
            if (burst_q != BURST_FIXED && burst_q != BURST_WRAP) begin
              addr_q <= addr_d;
            end
            state_q <= (rem_d == 9'd0) ? S_IDLE : S_CALC;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign RE        = ZRESET & (state_q == S_IDLE) & ~EMPTY;
  assign MCMDVALID = mvalid_q;
  assign MCMDID    = mid_q;
  assign MCMDADDR  = maddr_q;
  assign MCMDLEN   = mlen_q;
  assign MCMDSIZE  = msize_q;
  assign MCMDDIR   = mdir_q;
  assign MCMDLOCK  = mlock_q;
  assign MCMDWRAP  = mwrap_q;
  assign MCMDLAST  = mlast_q;
  assign DBGSTATE  = state_q;

endmodule

// File: tb/tb_ddr_a2m_reqdisp.sv
// Bench for ddr_a2m_reqdisp: FIFO model feeding requests, burst-splitting reference model
// filling an expected queue at pop time, and a monitor checking every command and its timing.
module tb_ddr_a2m_reqdisp;

  localparam int IW    = 8;
  localparam int AW    = 40;
  localparam int MAXBL = 16;
  localparam int BNDRY = 12;
  localparam int EW    = IW + AW + 8 + 3 + 4;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [2:0]    size;
    logic [1:0]    burst;
    logic          lock;
    logic          dir;
  } req_t;

  logic          CLK, ZRESET, EMPTY, RE;
  logic [IW-1:0] AXID;
  logic [AW-1:0] AXADDR;
  logic [7:0]    AXLEN;
  logic [2:0]    AXSIZE;
  logic [1:0]    AXBURST;
  logic          AXLOCK, AXDIR;
  logic          MCMDVALID, MCMDREADY;
  logic [IW-1:0] MCMDID;
  logic [AW-1:0] MCMDADDR;
  logic [7:0]    MCMDLEN;
  logic [2:0]    MCMDSIZE;
  logic          MCMDDIR, MCMDLOCK, MCMDWRAP, MCMDLAST;
  logic [1:0]    DBGSTATE;

  ddr_a2m_reqdisp #(.P_IW(IW), .P_AW(AW), .P_MAXBL(MAXBL), .P_BNDRY(BNDRY)) dut (
    .CLK(CLK), .ZRESET(ZRESET), .EMPTY(EMPTY), .RE(RE),
    .AXID(AXID), .AXADDR(AXADDR), .AXLEN(AXLEN), .AXSIZE(AXSIZE),
    .AXBURST(AXBURST), .AXLOCK(AXLOCK), .AXDIR(AXDIR),
    .MCMDVALID(MCMDVALID), .MCMDREADY(MCMDREADY), .MCMDID(MCMDID),
    .MCMDADDR(MCMDADDR), .MCMDLEN(MCMDLEN), .MCMDSIZE(MCMDSIZE),
    .MCMDDIR(MCMDDIR), .MCMDLOCK(MCMDLOCK), .MCMDWRAP(MCMDWRAP),
    .MCMDLAST(MCMDLAST), .DBGSTATE(DBGSTATE)
  );

  // ---------------- clock / reset / bookkeeping ----------------
  int          checks = 0;
  int          errors = 0;
  int          hs_cnt = 0;
  longint      cyc = 0;
  longint      exp_rise = -1;
  int          ready_mode = 0;
  req_t        req_q[$];
  logic [EW-1:0] exp_q[$];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [EW-1:0] pack(req_t r, logic [AW-1:0] a, logic [7:0] l,
                                         logic wrap, logic last);
    return {r.id, a, l, r.size, r.dir, r.lock, wrap, last};
  endfunction

  function automatic void model_push(req_t r);
    longint unsigned bsz, rem, cur, a, n;
`ifdef DDR_A2M_REQDISP_BNDSPLIT_EN
    longint unsigned room;
`endif
    bsz = 64'd1 << r.size;
    rem = 64'(r.len) + 1;
    cur = 64'(r.addr);
    if (r.burst == 2'b00) begin
      for (longint unsigned i = 0; i < rem; i++)
        exp_q.push_back(pack(r, r.addr, 8'd0, 1'b0, i == rem - 1));
    end else if (r.burst == 2'b10) begin
      exp_q.push_back(pack(r, r.addr, r.len, 1'b1, 1'b1));
    end else begin
      while (rem != 0) begin
        a = cur - (cur % bsz);
        n = (rem < MAXBL) ? rem : MAXBL;
`ifdef DDR_A2M_REQDISP_BNDSPLIT_EN
        room = ((64'd1 << BNDRY) - (a % (64'd1 << BNDRY))) / bsz;
        if (room < n) n = room;
`endif
        exp_q.push_back(pack(r, AW'(cur), 8'(n - 1), 1'b0, n == rem));
        cur = (a + n * bsz) % (64'd1 << AW);
        rem = rem - n;
      end
    end
  endfunction

  // ---------------- FIFO model and MBA ready driver ----------------
  task automatic drive_head();
    if (req_q.size() == 0) begin
      EMPTY = 1'b1;
    end else begin
      EMPTY   = 1'b0;
      AXID    = req_q[0].id;
      AXADDR  = req_q[0].addr;
      AXLEN   = req_q[0].len;
      AXSIZE  = req_q[0].size;
      AXBURST = req_q[0].burst;
      AXLOCK  = req_q[0].lock;
      AXDIR   = req_q[0].dir;
    end
  endtask

  initial begin
    bit pop_now;
    EMPTY = 1'b1; AXID = '0; AXADDR = '0; AXLEN = '0; AXSIZE = '0;
    AXBURST = '0; AXLOCK = 1'b0; AXDIR = 1'b0;
    forever begin
      @(negedge CLK);
      pop_now = RE && ZRESET;
      if (pop_now) begin
        model_push(req_q[0]);
        exp_rise = cyc + 2;
      end
      @(posedge CLK);
      #1;
      if (pop_now) void'(req_q.pop_front());
      drive_head();
    end
  end

  initial begin
    MCMDREADY = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      case (ready_mode)
        0:       MCMDREADY = 1'b1;
        1:       MCMDREADY = 1'($urandom_range(0, 1));
        default: MCMDREADY = 1'b0;
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [EW-1:0] cur, prev_vec, exp;
    bit prev_valid, prev_stall;
    prev_valid = 0; prev_stall = 0; prev_vec = '0;
    forever begin
      @(negedge CLK);
      if (!ZRESET) begin
        prev_valid = 0;
        prev_stall = 0;
      end else begin
        cur = {MCMDID, MCMDADDR, MCMDLEN, MCMDSIZE, MCMDDIR, MCMDLOCK, MCMDWRAP, MCMDLAST};
        checks++;
        if (RE && (EMPTY || MCMDVALID)) begin
          errors++;
          $display("FAIL re_guard: RE=%0b EMPTY=%0b MCMDVALID=%0b, RE required 0", RE, EMPTY, MCMDVALID);
        end
        if (MCMDVALID && !prev_valid) begin
          checks++;
          if (cyc != exp_rise) begin
            errors++;
            $display("FAIL valid_timing: rise at cycle %0d, required %0d", cyc, exp_rise);
          end
        end
        if (prev_stall) begin
          checks++;
          if (!MCMDVALID || cur != prev_vec) begin
            errors++;
            $display("FAIL stall_hold: valid=%0b cmd %h, required valid=1 cmd %h", MCMDVALID, cur, prev_vec);
          end
        end
        if (MCMDVALID && MCMDREADY) begin
          checks++;
          hs_cnt++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_cmd: got %h, no command expected", cur);
          end else begin
            exp = exp_q.pop_front();
            if (cur != exp) begin
              errors++;
              $display("FAIL cmd: got %h, required %h", cur, exp);
            end
            if (!MCMDLAST) exp_rise = cyc + 2;
          end
        end
        prev_stall = MCMDVALID && !MCMDREADY;
        prev_vec   = cur;
        prev_valid = MCMDVALID;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_req(input logic [1:0] burst, input logic [AW-1:0] addr,
                          input logic [7:0] len, input logic [2:0] size);
    req_t r;
    r.id = IW'($urandom); r.addr = addr; r.len = len; r.size = size;
    r.burst = burst; r.lock = 1'($urandom); r.dir = 1'($urandom);
    req_q.push_back(r);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (n < 20000 && !(req_q.size() == 0 && exp_q.size() == 0 && !MCMDVALID && DBGSTATE == 2'd0)) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (n >= 20000) begin
      errors++;
      $display("FAIL drain_%s: %0d requests %0d commands still pending, required 0", name, req_q.size(), exp_q.size());
      req_q.delete();
      exp_q.delete();
    end
  endtask

  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, base;
    logic [AW-1:0] a;
    ZRESET = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_val("rst_re", 64'(RE), 64'd0);
    check_val("rst_valid", 64'(MCMDVALID), 64'd0);
    check_val("rst_cmd", 64'({MCMDID, MCMDADDR, MCMDLEN, MCMDSIZE, MCMDDIR, MCMDLOCK, MCMDWRAP, MCMDLAST}), 64'd0);
    check_val("rst_state", 64'(DBGSTATE), 64'd0);
    @(posedge CLK);
    #2 ZRESET = 1'b1;

    ready_mode = 0;
    push_req(2'b01, 40'h1000, 8'd3, 3'd3);
    wait_idle("incr_single");
    push_req(2'b01, 40'h0, 8'd39, 3'd2);
    wait_idle("incr_split");
    push_req(2'b01, 40'hFF8, 8'd3, 3'd3);
    wait_idle("incr_bndry");
    push_req(2'b00, 40'h20, 8'd2, 3'd2);
    push_req(2'b10, 40'h30, 8'd7, 3'd2);
    wait_idle("fixed_wrap");
    for (int i = 0; i < 4; i++) push_req(2'b01, AW'(i * 64), 8'd0, 3'd3);
    wait_idle("back_to_back");

    // Stall with another request waiting in the FIFO.
    ready_mode = 2;
    push_req(2'b01, 40'h4000, 8'd3, 3'd2);
    push_req(2'b01, 40'h5000, 8'd0, 3'd2);
    n = 0;
    while (!MCMDVALID && n < 50) begin @(negedge CLK); n++; end
    check_val("stall_valid_seen", 64'(MCMDVALID), 64'd1);
    repeat (5) begin
      @(negedge CLK);
      check_val("stall_no_pop", 64'(RE), 64'd0);
    end
    ready_mode = 0;
    wait_idle("stall");

    // Reset in the middle of a split request; the following head must be popped afterwards.
    base = hs_cnt;
    push_req(2'b01, 40'h0, 8'd39, 3'd2);
    push_req(2'b01, 40'h2000, 8'd0, 3'd0);
    n = 0;
    while (hs_cnt < base + 1 && n < 100) begin @(negedge CLK); n++; end
    @(posedge CLK);
    #2 ZRESET = 1'b0;
    exp_q.delete();
    #1;
    check_val("midrst_valid", 64'(MCMDVALID), 64'd0);
    check_val("midrst_state", 64'(DBGSTATE), 64'd0);
    check_val("midrst_re", 64'(RE), 64'd0);
    repeat (2) @(posedge CLK);
    #2 ZRESET = 1'b1;
    wait_idle("after_reset");
    check_val("midrst_cmd_count", 64'(hs_cnt - base), 64'd2);

    // Randomised traffic with random backpressure.
    ready_mode = 1;
    for (int i = 0; i < 120; i++) begin
      a = {8'($urandom), 32'($urandom)};
      case ($urandom_range(0, 3))
        0: a[11:0] = 12'hF00 | 12'($urandom_range(0, 255));
        1: a[AW-1:12] = '1;
        default: ;
      endcase
      push_req(2'($urandom_range(0, 3)), a, 8'($urandom_range(0, 47)), 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 20)) @(negedge CLK);
    end
    wait_idle("random");
    ready_mode = 0;
    repeat (5) @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
